sd_filter: RTL and testbench

Second-order, single-bit sigma-delta modulator that converts a 16-bit signed audio sample stream into a 1-bit pulse-density stream. It sits between the audio sample source and the 1-bit output driver. It runs at the oversampled rate: OSR 256 × 44.1 kHz = 11.2896 MHz, a clock period of about 88.577 ns. Each enabled clock consumes one input sample and produces one output bit.

---
 rtl/sd_filter.sv | 80 ++++++++
 tb/tb_sd_filter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sd_filter.sv
// rtl/sd_filter.sv - second-order 1-bit sigma-delta modulator, 16-bit En7 in, pulse-density out
module sd_filter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [15:0] input_rsvd,
    output logic        ce_out,
    output logic        output_rsvd
);

    // Sums are carried at 26 bits: 24-bit integrator plus two 17-bit terms can never overflow this.
    localparam logic signed [25:0] FB_MAG  = 26'sd32768;
    localparam logic signed [25:0] SAT_MAX = 26'sd8388607;
    localparam logic signed [25:0] SAT_MIN = -26'sd8388608;

    logic signed [15:0] x_r_q, x_r_d;
    logic signed [23:0] i1_q, i1_d;
    logic signed [23:0] i2_q, i2_d;
    logic               out_q, out_d;
    logic               ce_q, ce_d;

    logic signed [25:0] fb;
    logic signed [25:0] sum1;
    logic signed [25:0] sum2;
    logic signed [23:0] i1_n;
    logic signed [23:0] i2_n;

    // Clamp a wide sum into the 24-bit integrator range instead of wrapping.
    function automatic logic signed [23:0] sat24(input logic signed [25:0] v);
        if (v > SAT_MAX) begin
            return 24'sh7FFFFF;
        end else if (v < SAT_MIN) begin
            return -24'sh800000;
        end else begin
            return $signed(v[23:0]);
        end
    endfunction

    // Integrator update; the input term uses the previously captured sample, giving two-edge latency.
    always_comb begin
        fb   = out_q ? FB_MAG : -FB_MAG;
        sum1 = $signed({{2{i1_q[23]}}, i1_q}) + $signed({{10{x_r_q[15]}}, x_r_q}) - fb;
        i1_n = sat24(sum1);
        sum2 = $signed({{2{i2_q[23]}}, i2_q}) + $signed({{2{i1_n[23]}}, i1_n}) - fb;
        i2_n = sat24(sum2);

        x_r_d = x_r_q;
        i1_d  = i1_q;
        i2_d  = i2_q;
        out_d = out_q;
        ce_d  = clk_enable;
        if (clk_enable) begin
            x_r_d = $signed(input_rsvd);
            i1_d  = i1_n;
            i2_d  = i2_n;
            out_d = (i2_n >= 0);
        end
    end

    // State registers; reset overrides the enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r_q <= '0;
            i1_q  <= '0;
            i2_q  <= '0;
            out_q <= 1'b0;
            ce_q  <= 1'b0;
        end else begin
            x_r_q <= x_r_d;
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            out_q <= out_d;
            ce_q  <= ce_d;
        end
    end

    assign output_rsvd = out_q;
    assign ce_out      = ce_q;

endmodule

// File: tb/tb_sd_filter.sv
// tb/tb_sd_filter.sv - scoreboard bench for sd_filter against a saturating reference model
module tb_sd_filter;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic [15:0] input_rsvd;
    logic        ce_out;
    logic        output_rsvd;

    int total;
    int bad;
    int ones;
    string phase;

    bit sb[$];
    bit mon_exp;

    longint m_x, m_i1, m_i2;
    bit     m_q;

    sd_filter dut (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .input_rsvd  (input_rsvd),
        .ce_out      (ce_out),
        .output_rsvd (output_rsvd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s [%s] actual=%0d expected=%0d t=%0t", name, phase, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s [%s] actual=%0d expected_range=%0d..%0d", name, phase, act, lo, hi);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 64'sd8388607) return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    // Reference model for the coming edge; each enabled edge pushes its expected bit.
    task automatic model_edge(input logic r, input logic en, input logic [15:0] d);
        longint fb, n1, n2;
        if (r) begin
            m_x = 0; m_i1 = 0; m_i2 = 0; m_q = 1'b0;
        end else if (en) begin
            fb   = m_q ? 64'sd32768 : -64'sd32768;
            n1   = sat(m_i1 + m_x - fb);
            n2   = sat(m_i2 + n1 - fb);
            m_i1 = n1;
            m_i2 = n2;
            m_q  = (n2 >= 0);
            m_x  = longint'($signed(d));
            sb.push_back(m_q);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [15:0] d);
        @(negedge clk);
        reset      = r;
        clk_enable = en;
        input_rsvd = d;
        model_edge(r, en, d);
        @(posedge clk);
        #2;
    endtask

    // Monitor: every qualified output bit is popped from the scoreboard and compared.
    always @(posedge clk) begin
        #1;
        if (ce_out === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                mon_exp = sb.pop_front();
                chk("out_bit", longint'(output_rsvd), longint'(mon_exp));
                if (output_rsvd === 1'b1) ones++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog [%s] actual=timeout expected=finish", phase);
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp7[7];
        bit last;
        bit seen1;
        logic [15:0] rnd;
        exp7 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        total = 0; bad = 0; ones = 0;
        m_x = 0; m_i1 = 0; m_i2 = 0; m_q = 1'b0;
        reset = 1'b1; clk_enable = 1'b1; input_rsvd = 16'h1234;

        phase = "reset";
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 16'h1234);
            chk("reset_out", longint'(output_rsvd), 0);
            chk("reset_ce", longint'(ce_out), 0);
        end

        phase = "zero";
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            step(1'b0, 1'b1, 16'h0000);
            if (i < 7) chk("zero_first_bits", longint'(output_rsvd), longint'(exp7[i]));
            if (i == 0) chk("ce_rise", longint'(ce_out), 1);
        end
        chk_range("zero_ones_1024", ones, 510, 514);

        phase = "dc_pos";
        for (int i = 0; i < 4096; i++) begin
            if (i == 2048) ones = 0;
            step(1'b0, 1'b1, 16'h4000);
        end
        chk_range("dc_pos_ones_2048", ones, 1516, 1556);

        phase = "dc_neg";
        for (int i = 0; i < 4096; i++) begin
            if (i == 2048) ones = 0;
            step(1'b0, 1'b1, 16'hC000);
        end
        chk_range("dc_neg_ones_2048", ones, 492, 532);

        phase = "gating";
        for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 16'h1000 + 16'(i));
        last = output_rsvd;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0, 16'h7777);
            chk("gate_ce_low", longint'(ce_out), 0);
            chk("gate_frozen", longint'(output_rsvd), longint'(last));
        end
        step(1'b0, 1'b1, 16'h1000);
        chk("gate_ce_back", longint'(ce_out), 1);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 16'h1000 - 16'(i));

        phase = "rail_pos";
        for (int i = 0; i < 10000; i++) begin
            if (i == 1808) ones = 0;
            step(1'b0, 1'b1, 16'h7FFF);
        end
        chk_range("rail_pos_ones_8192", ones, 8111, 8192);

        phase = "rail_neg";
        for (int i = 0; i < 10000; i++) begin
            if (i == 1808) ones = 0;
            step(1'b0, 1'b1, 16'h8000);
        end
        chk_range("rail_neg_ones_8192", ones, 0, 81);

        phase = "rail_recover";
        seen1 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, 16'h0000);
            if (output_rsvd === 1'b1) seen1 = 1'b1;
        end
        chk("rail_recover_one_seen", longint'(seen1), 1);

        phase = "noise";
        for (int i = 0; i < 16384; i++) begin
            rnd = 16'($urandom_range(16384)) - 16'd8192;
            if (i == 8000 || i == 8001) begin
                step(1'b1, 1'b1, rnd);
                chk("midreset_out", longint'(output_rsvd), 0);
                chk("midreset_ce", longint'(ce_out), 0);
            end else begin
                step(1'b0, 1'b1, rnd);
            end
        end

        phase = "drain";
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
